operand_loader: RTL

- Drives one 32-entry operand register bank in the matrix-multiply datapath.
- Accepts a burst of DEPTH words on a valid/ready input stream.
- Writes each word to consecutive bank addresses and emits one clean register_ready pulse per write. Every pulse is one cycle high followed by at least one cycle low, so downstream edge-triggered load counters count every write exactly once.
- Pulses done when the bank is full. The control FSM then issues the next batch with start.

---
 rtl/operand_loader_if.sv | 30 +++
 rtl/operand_loader.sv | 138 +++++++++++++
 2 files changed

// File: rtl/operand_loader_if.sv
// Stream-in and register-bank-out signal bundle for the operand loader.
// The master side feeds operands and observes the bank write port; the slave side is the loader.
interface operand_loader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              start;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              reg_wr_en;
  logic [ADDR_W-1:0] reg_wr_addr;
  logic [DATA_W-1:0] reg_wr_data;
  logic              register_ready;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] load_cnt;

  modport master (
    output start, in_data, in_valid,
    input  in_ready, reg_wr_en, reg_wr_addr, reg_wr_data,
    input  register_ready, busy, done, load_cnt
  );

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, reg_wr_en, reg_wr_addr, reg_wr_data,
    output register_ready, busy, done, load_cnt
  );
endinterface

// File: rtl/operand_loader.sv
// Loads one batch of DEPTH operands into consecutive bank addresses, one write every
// other cycle so each register_ready pulse is followed by at least one low cycle.
//
// state    | meaning
// S_IDLE   | waiting for start, not ready
// S_LOAD   | ready, waiting for an accepted word
// S_GAP    | write cycle of the accepted word, not ready
// S_FINISH | done pulse, load_cnt has wrapped to 0
module operand_loader #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  operand_loader_if.slave       bus
);
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_GAP    = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_in_ready;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [DATA_W-1:0] r_wr_data;
  logic              r_reg_ready;
  logic              r_busy;
  logic              r_done;
  logic [ADDR_W-1:0] r_load_cnt;

  logic              w_in_ready_nxt;
  logic              w_wr_en_nxt;
  logic [ADDR_W-1:0] w_wr_addr_nxt;
  logic [DATA_W-1:0] w_wr_data_nxt;
  logic              w_reg_ready_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;
  logic [ADDR_W-1:0] w_load_cnt_nxt;
  logic              w_accept;
  logic              w_last_elem;

  assign w_accept    = bus.in_valid && r_in_ready;
  assign w_last_elem = (r_load_cnt == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_in_ready_nxt  = r_in_ready;
    w_wr_en_nxt     = 1'b0;
    w_reg_ready_nxt = 1'b0;
    w_done_nxt      = 1'b0;
    w_wr_addr_nxt   = r_wr_addr;
    w_wr_data_nxt   = r_wr_data;
    w_busy_nxt      = r_busy;
    w_load_cnt_nxt  = r_load_cnt;
    unique case (r_state)
      S_IDLE: begin
        w_in_ready_nxt = 1'b0;
        w_busy_nxt     = 1'b0;
        if (bus.start) begin
          w_state_nxt    = S_LOAD;
          w_in_ready_nxt = 1'b1;
          w_busy_nxt     = 1'b1;
          w_load_cnt_nxt = '0;
        end
      end
      S_LOAD: begin
        if (w_accept) begin
          w_state_nxt     = S_GAP;
          w_in_ready_nxt  = 1'b0;
          w_wr_en_nxt     = 1'b1;
          w_reg_ready_nxt = 1'b1;
          w_wr_addr_nxt   = r_load_cnt;
          w_wr_data_nxt   = bus.in_data;
        end
      end
      S_GAP: begin
        // Counter wraps naturally in ADDR_W bits after the last element.
        w_load_cnt_nxt = r_load_cnt + 1'b1;
        if (w_last_elem) begin
          w_state_nxt    = S_FINISH;
          w_in_ready_nxt = 1'b0;
          w_done_nxt     = 1'b1;
        end else begin
          w_state_nxt    = S_LOAD;
          w_in_ready_nxt = 1'b1;
        end
      end
      S_FINISH: begin
        w_state_nxt    = S_IDLE;
        w_in_ready_nxt = 1'b0;
        w_busy_nxt     = 1'b0;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_ready  <= 1'b0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_reg_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_load_cnt  <= '0;
    end else begin
      r_in_ready  <= w_in_ready_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_reg_ready <= w_reg_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_load_cnt  <= w_load_cnt_nxt;
    end
  end

  assign bus.in_ready       = r_in_ready;
  assign bus.reg_wr_en      = r_wr_en;
  assign bus.reg_wr_addr    = r_wr_addr;
  assign bus.reg_wr_data    = r_wr_data;
  assign bus.register_ready = r_reg_ready;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.load_cnt       = r_load_cnt;
endmodule
